riscv_crypto_aes64_enc_seq: RTL and testbench
=============================================

// Module: riscv_crypto_aes64_enc_seq
// PURPOSE
//  Multi-cycle execute unit for the Zkne aes64es / aes64esm instructions.
//  Applies forward ShiftRows, then SubBytes through riscv_crypto_aes_sbox lanes,
//  and optionally MixColumns. Time-multiplexes a small number of S-box lanes
//  to save area. Sits in the execute stage beside the ALU; result returns via done_o.
// PARAMETERS
//  SBOX_LANES  4  S-box instances; legal values 4 (two SUB cycles) or 8 (one SUB cycle)
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   asynchronous, active-high reset
//  start_i   in   1   request; accepted only when busy_o=0
//  mix_i     in   1   1=aes64esm (apply MixColumns), 0=aes64es; sampled at accept
//  rs1_i     in   64  state bytes 0..7 (byte i = rs1_i[8i+:8])
//  rs2_i     in   64  state bytes 8..15 (byte 8+i = rs2_i[8i+:8])
//  kill_i    in   1   pipeline flush; aborts the operation in flight
//  busy_o    out  1   operation in progress
//  done_o    out  1   one-cycle pulse; result_o valid
//  result_o  out  64  rd value
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, busy_o=0, done_o=0, result_o=0, internal regs=0.
//  Byte/column mapping: 16-byte state, byte i at row i%4, column i/4.
//  ShiftRows, low half only, sampled at accept into a 64-bit register:
//    sr = {b3,b14,b9,b4,b15,b10,b5,b0} (byte7..byte0).
//  FSM: IDLE -> SUB0 -> SUB1 -> MIX -> IDLE (SBOX_LANES=4).
//       With SBOX_LANES=8, SUB1 is skipped: IDLE -> SUB0 -> MIX.
//   IDLE: start_i=1 -> latch sr and mix_i, go SUB0, busy_o=1 next cycle.
//   SUB0: sbox(sr bytes 0..3) written to sub[31:0] (all 8 bytes if 8 lanes).
//   SUB1: sbox(sr bytes 4..7) written to sub[63:32].
//   MIX:  result_o <= mix ? {MC(sub[63:32]),MC(sub[31:0])} : sub.
//         done_o=1 next cycle, concurrent with return to IDLE.
//  MC: standard AES MixColumns on one 32-bit column.
//    Byte0 of the column is row 0; multiply by 2 = xtime, reduction polynomial 0x11B.
//  Latency: accept at cycle N -> done_o at cycle N+4 (4 lanes) or N+3 (8 lanes).
//  Throughput: one op per 4 (or 3) cycles.
//  Back-to-back: start_i in the done_o cycle is accepted, since busy_o=0 then.
//  busy_o=1 in SUB0, SUB1 and MIX; 0 in IDLE.
//  start_i while busy_o=1 is ignored; the caller must hold it.
//  result_o holds its last value until the next MIX write; it is not cleared on accept.
//  kill_i: in any non-IDLE state -> IDLE next cycle; no done_o; result_o unchanged.
//    kill_i has priority over start_i in the same cycle.
//  S-box lanes are purely combinational; the S-box input mux is driven by the FSM state.
//  No X may reach result_o. Operand registers load only on accept.
// TESTING
//  1 es zero: rs1=0, rs2=0, mix=0 -> result_o=64'h6363636363636363, done_o at accept+4.
//  2 esm zero: same operands, mix=1 -> 64'h6363636363636363.
//    A constant column is invariant under MixColumns.
//  3 SubBytes+MC: rs1=64'h53, rs2=0 -> es: 64'h63636363636363ED; esm: 64'h63636363EAEDED64.
//  4 ShiftRows: rs1=0, rs2=64'h5300000000000000, mix=0 -> 64'h63636363ED636363.
//    Byte 15 moves to byte 3.
//  5 Handshake: start_i held across busy; back-to-back in done cycle; start during busy ignored.
//    Also kill_i in SUB1 -> no done_o, result_o unchanged, next op correct.
//  6 Reset mid-op in SUB0 -> outputs 0 immediately; then a random regression vs golden model.
//    Golden: aes64es/esm reference model, 10k vectors, both SBOX_LANES values.

Source files
------------

// File: rtl/riscv_crypto_aes64_enc_seq.sv
// riscv_crypto_aes64_enc_seq
//   Multi-cycle execute unit for the Zkne aes64es / aes64esm instructions.
//   Computes the low 64 bits of ShiftRows -> SubBytes -> (optional) MixColumns
//   over the 128-bit state {rs2_i, rs1_i}. SBOX_LANES (4 or 8) S-box lanes
//   are time-multiplexed over the eight state bytes.
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start_i   request, accepted only while busy_o=0
//   mix_i     1 = aes64esm (MixColumns applied), 0 = aes64es; sampled at accept
//   rs1_i     state bytes 0..7
//   rs2_i     state bytes 8..15
//   kill_i    flush; aborts the operation in flight without done_o
//   busy_o    operation in progress
//   done_o    one-cycle pulse, result_o valid
//   result_o  rd value, held until the next completed operation
module riscv_crypto_aes64_enc_seq #(
  parameter int unsigned SBOX_LANES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        mix_i,
  input  logic [63:0] rs1_i,
  input  logic [63:0] rs2_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] result_o
);

  localparam int unsigned LW = SBOX_LANES * 8;

  typedef enum logic [1:0] {IDLE, SUB0, SUB1, MIX} state_e;

  state_e      state_q, state_d;
  logic [63:0] sr_q, sr_d;
  logic        mix_q, mix_d;
  logic [63:0] sub_q, sub_d;
  logic [63:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [LW-1:0] lane_in;
  logic [LW-1:0] lane_out;
  logic [63:0]   sub_wr;
  logic [63:0]   sr_in;

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as x^254 (0 maps to 0), then affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; byte 0 (bits 7:0) is row 0.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

  // Low half of ShiftRows: {b3,b14,b9,b4,b15,b10,b5,b0}.
  assign sr_in = {rs1_i[31:24], rs2_i[55:48], rs2_i[15:8],  rs1_i[39:32],
                  rs2_i[63:56], rs2_i[23:16], rs1_i[47:40], rs1_i[7:0]};

  // The other state bytes only feed the discarded upper result half.
  logic unused_bytes;
  assign unused_bytes = ^{rs1_i[23:8], rs1_i[63:48], rs2_i[7:0], rs2_i[47:24]};

  for (genvar g = 0; g < int'(SBOX_LANES); g++) begin : g_lane
    assign lane_out[8*g +: 8] = aes_sbox(lane_in[8*g +: 8]);
  end

  if (SBOX_LANES == 8) begin : g_lanes8
    always_comb begin
      lane_in = sr_q;
      sub_wr  = lane_out;
    end
  end else begin : g_lanes4
    // SUB0 works on the low four bytes, SUB1 on the high four.
    always_comb begin
      lane_in = (state_q == SUB1) ? sr_q[63:32] : sr_q[31:0];
      sub_wr  = (state_q == SUB1) ? {lane_out, sub_q[31:0]} : {sub_q[63:32], lane_out};
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    mix_d    = mix_q;
    sub_d    = sub_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !kill_i) begin
          sr_d    = sr_in;
          mix_d   = mix_i;
          state_d = SUB0;
          busy_d  = 1'b1;
        end
      end
      SUB0: begin
        sub_d   = sub_wr;
        state_d = (SBOX_LANES == 8) ? MIX : SUB1;
      end
      SUB1: begin
        sub_d   = sub_wr;
        state_d = MIX;
      end
      MIX: begin
        result_d = mix_q ? {mix_col(sub_q[63:32]), mix_col(sub_q[31:0])} : sub_q;
        state_d  = IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // Flush wins over everything in flight, including the MIX write-back.
    if (kill_i && state_q != IDLE) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      mix_q    <= 1'b0;
      sub_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      mix_q    <= mix_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_riscv_crypto_aes64_enc_seq.sv
// Bench for riscv_crypto_aes64_enc_seq: one instance per SBOX_LANES value,
// sharing stimulus; expected values come from a byte-array AES model.
module tb_riscv_crypto_aes64_enc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mix;
  logic        kill;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        busy4, done4, busy8, done8;
  logic [63:0] res4, res8;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  sbox_t [256];

  always #5 clk = ~clk;

  riscv_crypto_aes64_enc_seq #(.SBOX_LANES(4)) dut4 (
    .clk(clk), .reset(reset), .start_i(start), .mix_i(mix), .rs1_i(rs1), .rs2_i(rs2),
    .kill_i(kill), .busy_o(busy4), .done_o(done4), .result_o(res4)
  );

  riscv_crypto_aes64_enc_seq #(.SBOX_LANES(8)) dut8 (
    .clk(clk), .reset(reset), .start_i(start), .mix_i(mix), .rs1_i(rs1), .rs2_i(rs2),
    .kill_i(kill), .busy_o(busy8), .done_o(done8), .result_o(res8)
  );

  // Polynomial product then long-division reduction by 0x11B.
  function automatic logic [7:0] gmul(input int unsigned a, input int unsigned b);
    int unsigned p = 0;
    for (int i = 0; i < 8; i++) if ((b >> i) & 1) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--) if ((p >> i) & 1) p = p ^ (32'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      int unsigned inv = 0;
      int unsigned s;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 8'h01) inv = y;
      s = inv;
      for (int k = 1; k < 5; k++) s = s ^ (((inv << k) | (inv >> (8 - k))) & 255);
      s = s ^ 32'h63;
      sbox_t[x] = s[7:0];
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic m);
    logic [7:0]  st [16];
    logic [7:0]  o  [8];
    logic [63:0] r;
    int unsigned coef [4] = '{2, 3, 1, 1};
    for (int i = 0; i < 8; i++) begin
      st[i]     = a[8*i +: 8];
      st[8 + i] = b[8*i +: 8];
    end
    // Output row r, column c takes input row r, column (c + r) mod 4.
    for (int j = 0; j < 8; j++) o[j] = sbox_t[st[(j % 4) + 4 * (((j / 4) + (j % 4)) % 4)]];
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (m) begin
        logic [7:0] acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - (j % 4) + 4) % 4], o[4 * (j / 4) + k]);
        r[8*j +: 8] = acc;
      end else begin
        r[8*j +: 8] = o[j];
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one op to both instances and check result, latency and pulse count.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic m,
                        input logic [63:0] exp, input string tag);
    int unsigned lat4 = 0, lat8 = 0, n4 = 0, n8 = 0;
    logic [63:0] r4 = '0, r8 = '0;
    @(negedge clk);
    rs1 = a; rs2 = b; mix = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (done4) begin n4++; if (lat4 == 0) begin lat4 = k; r4 = res4; end end
      if (done8) begin n8++; if (lat8 == 0) begin lat8 = k; r8 = res8; end end
      @(negedge clk);
    end
    check({tag, " res4"}, r4, exp);
    check({tag, " res8"}, r8, exp);
    check({tag, " lat4"}, 64'(lat4), 64'd4);
    check({tag, " lat8"}, 64'(lat8), 64'd3);
    check({tag, " pulses4"}, 64'(n4), 64'd1);
    check({tag, " pulses8"}, 64'(n8), 64'd1);
  endtask

  task automatic wait_done4(output int unsigned k);
    k = 1;
    while (!done4 && k < 10) begin @(negedge clk); k++; end
  endtask

  initial begin
    logic [63:0] a1, a2, b1, b2, exp_prev;
    logic        ma, mb;
    int unsigned k, n;

    reset = 1'b1; start = 1'b0; mix = 1'b0; kill = 1'b0; rs1 = '0; rs2 = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("reset flags", {60'd0, busy4, done4, busy8, done8}, 64'd0);
    check("reset res4", res4, 64'd0);
    check("reset res8", res8, 64'd0);
    reset = 1'b0;

    run_op(64'h0, 64'h0, 1'b0, 64'h6363636363636363, "es zero");
    run_op(64'h0, 64'h0, 1'b1, 64'h6363636363636363, "esm zero");
    run_op(64'h53, 64'h0, 1'b0, 64'h63636363636363ED, "es 53");
    run_op(64'h53, 64'h0, 1'b1, 64'h63636363EAEDED64, "esm 53");
    run_op(64'h0, 64'h5300000000000000, 1'b0, 64'h63636363ED636363, "shiftrows");

    // Held start with operands changing while busy, then back-to-back in the done cycle.
    a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom}; ma = 1'($urandom_range(0, 1));
    b1 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; mb = 1'($urandom_range(0, 1));
    @(negedge clk);
    rs1 = a1; rs2 = a2; mix = ma; start = 1'b1;
    @(negedge clk);
    check("busy after accept", 64'(busy4), 64'd1);
    rs1 = b1; rs2 = b2; mix = mb;
    wait_done4(k);
    check("held lat", 64'(k), 64'd4);
    check("held res", res4, model(a1, a2, ma));
    check("busy in done cycle", 64'(busy4), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("b2b busy", 64'(busy4), 64'd1);
    wait_done4(k);
    check("b2b lat", 64'(k), 64'd4);
    exp_prev = model(b1, b2, mb);
    check("b2b res", res4, exp_prev);
    repeat (6) @(negedge clk);

    // Kill while the 4-lane instance is in SUB1.
    @(negedge clk);
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom}; mix = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy", 64'(busy4), 64'd0);
    n = 0;
    repeat (5) begin
      if (done4) n++;
      @(negedge clk);
    end
    check("kill no done", 64'(n), 64'd0);
    check("kill res held", res4, exp_prev);
    a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom};
    run_op(a1, a2, 1'b1, model(a1, a2, 1'b1), "after kill");

    // Asynchronous reset while in SUB0.
    @(negedge clk);
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("midop reset flags", {60'd0, busy4, done4, busy8, done8}, 64'd0);
    check("midop reset res4", res4, 64'd0);
    check("midop reset res8", res8, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5000; v++) begin
      a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom}; ma = 1'($urandom_range(0, 1));
      run_op(a1, a2, ma, model(a1, a2, ma), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
